// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point add/subtract block: FSM states,
// default field widths, guard-bit count and the canonical quiet-NaN pattern.
package fp_pkg;

    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, DONE} state_t;

    localparam int DEF_EXP_W = 8;
    localparam int DEF_MAN_W = 23;
    localparam int GRS_W     = 3;

    // {0, all-ones exponent, mantissa MSB set}, right-aligned in 64 bits
    function automatic logic [63:0] canon_nan(input int exp_w, input int man_w);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < exp_w; i++) v[man_w + i] = 1'b1;
        v[man_w - 1] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// Parametrised leading-zero counter; an all-zero input reports WIDTH.
module fp_lzc
    import fp_pkg::*;
#(
    parameter int WIDTH = 27,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] value,
    output logic [CNT_W-1:0] count
);

    // Ascending scan: the highest set bit is written last and wins.
    always_comb begin
        count = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++)
            if (value[i]) count = CNT_W'(WIDTH - 1 - i);
    end

endmodule

// File: rtl/fp_addsub.sv
// Multi-cycle IEEE-754-style adder/subtractor: IDLE->ALIGN->ADD->NORM->ROUND->DONE,
// round-to-nearest-even, denormals flushed to signed zero.
module fp_addsub
    import fp_pkg::*;
#(
    parameter  int EXP_W = DEF_EXP_W,
    parameter  int MAN_W = DEF_MAN_W,
    localparam int W     = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         op,
    input  logic [W-1:0] dataa,
    input  logic [W-1:0] datab,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic [2:0]   flags
);

    localparam int M     = MAN_W + 1 + GRS_W;
    localparam int CNT_W = $clog2(M + 1);
    localparam int XW    = (EXP_W + 2 > CNT_W + 1) ? EXP_W + 2 : CNT_W + 1;
    localparam logic [W-1:0]  QNAN    = W'(canon_nan(EXP_W, MAN_W));
    localparam logic [XW-1:0] EXP_MAX = XW'({EXP_W{1'b1}});

    state_t state;

    logic [W-1:0]     a_p0, b_p0;
    logic             sign_p1, eff_sub_p1, zero_sign_p1, special_p1;
    logic [EXP_W-1:0] exp_p1;
    logic [M-1:0]     big_p1, small_p1;
    logic [W-1:0]     special_res_p1;
    logic [2:0]       special_flags_p1;
    logic [M:0]       sum_p2;
    logic [M-1:0]     mant_p3;
    logic [XW-1:0]    exp_p3;
    logic             zero_p3, flush_p3;

    assign in_ready = (state == IDLE) && !reset;

    function automatic logic [MAN_W+1:0] round_rne(input logic [M-1:0] m);
        logic up;
        up = m[2] & (m[1] | m[0] | m[3]);
        return {1'b0, m[M-1:GRS_W]} + (MAN_W+2)'(up);
    endfunction

    // ---- ALIGN: classify, flush denormals, order by magnitude, shift small
    logic             sa, sb, a_nan, b_nan, a_inf, b_inf, a_big;
    logic [W-2:0]     a_mag, b_mag, big_mag, small_mag;
    logic [EXP_W-1:0] e_big, e_small, shift_d;
    logic [M-1:0]     big_ext, small_ext, small_al;
    logic [2*M-1:0]   small_wide;
    logic             spec;
    logic [W-1:0]     spec_res;
    logic [2:0]       spec_flags;

    always_comb begin
        sa        = a_p0[W-1];
        sb        = b_p0[W-1];
        a_nan     = (&a_p0[W-2:MAN_W]) && (|a_p0[MAN_W-1:0]);
        b_nan     = (&b_p0[W-2:MAN_W]) && (|b_p0[MAN_W-1:0]);
        a_inf     = (&a_p0[W-2:MAN_W]) && !(|a_p0[MAN_W-1:0]);
        b_inf     = (&b_p0[W-2:MAN_W]) && !(|b_p0[MAN_W-1:0]);
        a_mag     = (a_p0[W-2:MAN_W] == '0) ? '0 : a_p0[W-2:0];
        b_mag     = (b_p0[W-2:MAN_W] == '0) ? '0 : b_p0[W-2:0];
        a_big     = a_mag >= b_mag;
        big_mag   = a_big ? a_mag : b_mag;
        small_mag = a_big ? b_mag : a_mag;
        e_big     = big_mag[W-2:MAN_W];
        e_small   = small_mag[W-2:MAN_W];
        big_ext   = {|e_big, big_mag[MAN_W-1:0], {GRS_W{1'b0}}};
        small_ext = {|e_small, small_mag[MAN_W-1:0], {GRS_W{1'b0}}};
        shift_d   = e_big - e_small;
        small_wide = {small_ext, {M{1'b0}}} >> shift_d;
        if (int'(shift_d) >= M)
            small_al = {{(M-1){1'b0}}, |small_ext};
        else
            small_al = {small_wide[2*M-1:M+1], small_wide[M] | (|small_wide[M-1:0])};

        spec       = 1'b1;
        spec_res   = QNAN;
        spec_flags = '0;
        if (a_nan || b_nan)
            spec_flags = {(a_nan && !a_p0[MAN_W-1]) || (b_nan && !b_p0[MAN_W-1]), 2'b00};
        else if (a_inf && b_inf && (sa != sb))
            spec_flags = 3'b100;
        else if (a_inf)
            spec_res = a_p0;
        else if (b_inf)
            spec_res = b_p0;
        else
            spec = 1'b0;
    end

    // ---- ADD: big minus small never goes negative
    logic [M:0] sum;
    assign sum = eff_sub_p1 ? ({1'b0, big_p1} - {1'b0, small_p1})
                            : ({1'b0, big_p1} + {1'b0, small_p1});

    // ---- NORM: carry right-shift, or left-shift clamped at exponent 1
    logic [CNT_W-1:0] lz;
    logic [XW-1:0]    lim, cnt, sh, norm_exp;
    logic [M-1:0]     norm_mant;

    fp_lzc #(.WIDTH(M), .CNT_W(CNT_W)) u_lzc (
        .value (sum_p2[M-1:0]),
        .count (lz)
    );

    always_comb begin
        lim = (exp_p1 == '0) ? '0 : XW'(exp_p1) - XW'(1);
        cnt = XW'(lz);
        sh  = (cnt < lim) ? cnt : lim;
        if (sum_p2[M]) begin
            norm_mant = {sum_p2[M:2], sum_p2[1] | sum_p2[0]};
            norm_exp  = XW'(exp_p1) + XW'(1);
        end else begin
            norm_mant = sum_p2[M-1:0] << sh;
            norm_exp  = XW'(exp_p1) - sh;
        end
    end

    // ---- ROUND: RNE, then zero / flush / overflow / special selection
    logic [MAN_W+1:0] rnd;
    logic [XW-1:0]    exp_r;
    logic [MAN_W-1:0] man_r;
    logic [W-1:0]     res_n;
    logic [2:0]       flags_n;

    always_comb begin
        rnd     = round_rne(mant_p3);
        exp_r   = exp_p3 + XW'(rnd[MAN_W+1]);
        man_r   = rnd[MAN_W+1] ? rnd[MAN_W:1] : rnd[MAN_W-1:0];
        res_n   = {sign_p1, exp_r[EXP_W-1:0], man_r};
        flags_n = {2'b00, |mant_p3[GRS_W-1:0]};
        if (special_p1) begin
            res_n   = special_res_p1;
            flags_n = special_flags_p1;
        end else if (zero_p3) begin
            res_n   = {zero_sign_p1, {(W-1){1'b0}}};
            flags_n = 3'b000;
        end else if (flush_p3) begin
            res_n   = {sign_p1, {(W-1){1'b0}}};
            flags_n = 3'b001;
        end else if (exp_r >= EXP_MAX) begin
            res_n   = {sign_p1, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flags_n = 3'b011;
        end
    end

    always_ff @(posedge clk) begin
        case (state)
            IDLE: if (in_valid) begin
                a_p0 <= dataa;
                b_p0 <= {datab[W-1] ^ op, datab[W-2:0]};
            end
            ALIGN: begin
                sign_p1          <= a_big ? sa : sb;
                eff_sub_p1       <= sa ^ sb;
                zero_sign_p1     <= sa & sb;
                exp_p1           <= e_big;
                big_p1           <= big_ext;
                small_p1         <= small_al;
                special_p1       <= spec;
                special_res_p1   <= spec_res;
                special_flags_p1 <= spec_flags;
            end
            ADD: sum_p2 <= sum;
            NORM: begin
                mant_p3  <= norm_mant;
                exp_p3   <= norm_exp;
                zero_p3  <= (sum_p2 == '0);
                flush_p3 <= (sum_p2 != '0) && !norm_mant[M-1];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
        end else begin
            case (state)
                IDLE:  if (in_valid) state <= ALIGN;
                ALIGN: state <= ADD;
                ADD:   state <= NORM;
                NORM:  state <= ROUND;
                ROUND: begin
                    result    <= res_n;
                    flags     <= flags_n;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_addsub.sv
// Randomised and directed bench for fp_addsub against an exact-arithmetic model.
module tb_fp_addsub;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, op, out_valid, out_ready;
    logic [31:0] dataa, datab, result;
    logic [2:0]  flags;
    logic        w_in_valid, w_in_ready, w_op, w_out_valid, w_out_ready;
    logic [63:0] w_a, w_b, w_result;
    logic [2:0]  w_flags;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    fp_addsub dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .dataa(dataa), .datab(datab), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flags(flags)
    );

    fp_addsub #(.EXP_W(11), .MAN_W(52)) dut_w (
        .clk(clk), .reset(reset), .in_valid(w_in_valid), .in_ready(w_in_ready), .op(w_op),
        .dataa(w_a), .datab(w_b), .out_valid(w_out_valid), .out_ready(w_out_ready),
        .result(w_result), .flags(w_flags)
    );

    // Exact value: significand * 2^(biased_exp - 1) in units of 2^-149.
    function automatic void ref_model(input logic [31:0] a, input logic [31:0] b,
                                      input logic o, output logic [31:0] r,
                                      output logic [2:0] f);
        logic sa, sb, sign, g, st;
        int ea, eb, p, e;
        logic [279:0] ma, mb, s, q, mask;
        sa = a[31];
        sb = b[31] ^ o;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0)) begin
            r = 32'h7FC00000;
            f = {(ea == 255 && a[22:0] != 0 && !a[22]) || (eb == 255 && b[22:0] != 0 && !b[22]), 2'b00};
            return;
        end
        if (ea == 255 && eb == 255 && sa != sb) begin
            r = 32'h7FC00000; f = 3'b100; return;
        end
        if (ea == 255) begin r = {sa, 8'hFF, 23'h0}; f = 3'b000; return; end
        if (eb == 255) begin r = {sb, 8'hFF, 23'h0}; f = 3'b000; return; end
        ma = (ea == 0) ? '0 : (280'({1'b1, a[22:0]}) << (ea - 1));
        mb = (eb == 0) ? '0 : (280'({1'b1, b[22:0]}) << (eb - 1));
        if (sa == sb)      begin s = ma + mb; sign = sa; end
        else if (ma >= mb) begin s = ma - mb; sign = sa; end
        else               begin s = mb - ma; sign = sb; end
        if (s == '0) begin r = {sa & sb, 31'h0}; f = 3'b000; return; end
        p = 0;
        for (int i = 0; i < 280; i++) if (s[i]) p = i;
        e = p - 22;
        if (e <= 0) begin r = {sign, 31'h0}; f = 3'b001; return; end
        q    = s >> (p - 23);
        g    = (p >= 24) ? s[p-24] : 1'b0;
        mask = (p >= 25) ? ((280'(1) << (p - 24)) - 280'(1)) : '0;
        st   = |(s & mask);
        if (g && (st || q[0])) q = q + 280'(1);
        if (q[24]) begin q = q >> 1; e++; end
        if (e >= 255) begin r = {sign, 8'hFF, 23'h0}; f = 3'b011; return; end
        r = {sign, e[7:0], q[22:0]};
        f = {2'b00, g | st};
    endfunction

    function automatic logic [31:0] rand_operand(input int e);
        logic [31:0] v;
        v = {1'($urandom), 8'(e), 23'($urandom)};
        case ($urandom_range(0, 19))
            0: v[30:0] = '0;
            1: v[30:0] = {8'hFF, 23'h0};
            2: v[30:0] = {8'hFF, 1'b0, 22'($urandom) | 22'h1};
            3: v[30:22] = 9'h1FF;
            4: v[30:23] = 8'h00;
            5: v[30:0] = 31'h7F7FFFFF;
            default: ;
        endcase
        return v;
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic o,
                          output logic [31:0] r, output logic [2:0] f, output int lat);
        int t;
        lat = -1;
        r   = 'x;
        f   = 'x;
        t   = 0;
        while (!in_ready && t < 20) begin @(negedge clk); t++; end
        if (!in_ready) begin
            n_vec++; n_err++;
            $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
            return;
        end
        dataa = a; datab = b; op = o; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (out_valid) begin lat = c; break; end
            @(negedge clk);
        end
        if (lat < 0) return;
        r = result;
        f = flags;
        if (out_ready) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_vec += 5;
        if (in_ready !== 1'b0)   begin n_err++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        if (out_valid !== 1'b0)  begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        if (result !== 32'h0)    begin n_err++; $display("FAIL rst_result: got %h want 0", result); end
        if (flags !== 3'b000)    begin n_err++; $display("FAIL rst_flags: got %b want 000", flags); end
        if (w_in_ready !== 1'b0) begin n_err++; $display("FAIL rst_w_in_ready: got %b want 0", w_in_ready); end
        reset = 1'b0;
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_in_ready: got %b want 1", in_ready); end
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [31:0] da [0:11], db [0:11], dr [0:11], r;
        logic [2:0]  df [0:11], f;
        logic        dop [0:11];
        int lat;
        da  = '{32'h3F800000, 32'h3F800000, 32'h80000000, 32'h7F7FFFFF, 32'h7F800000, 32'h3F800000,
                32'h3F800000, 32'h7F800000, 32'h7F800001, 32'h7FC00001, 32'h00000001, 32'h00C00000};
        db  = '{32'h40000000, 32'h3F800000, 32'h80000000, 32'h7F7FFFFF, 32'h7F800000, 32'h33800000,
                32'h33800001, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h00000001, 32'h00800000};
        dop = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        dr  = '{32'h40400000, 32'h00000000, 32'h80000000, 32'h7F800000, 32'h7FC00000, 32'h3F800000,
                32'h3F800001, 32'h7F800000, 32'h7FC00000, 32'h7FC00000, 32'h00000000, 32'h00000000};
        df  = '{3'b000, 3'b000, 3'b000, 3'b011, 3'b100, 3'b001,
                3'b001, 3'b000, 3'b100, 3'b000, 3'b000, 3'b001};
        for (int i = 0; i < 12; i++) begin
            run_op(da[i], db[i], dop[i], r, f, lat);
            n_vec += 4;
            if (r !== dr[i])   begin n_err++; $display("FAIL dir%0d_result: got %h want %h", i, r, dr[i]); end
            if (f !== df[i])   begin n_err++; $display("FAIL dir%0d_flags: got %b want %b", i, f, df[i]); end
            if (lat !== 5)     begin n_err++; $display("FAIL dir%0d_latency: got %0d want 5", i, lat); end
            if (in_ready !== 1'b1) begin n_err++; $display("FAIL dir%0d_ready_after: got %b want 1", i, in_ready); end
        end
    endtask

    task automatic test_random(input int n);
        logic [31:0] a, b, r, er;
        logic [2:0]  f, ef;
        logic        o;
        int base, e2, lat, k;
        for (int i = 0; i < n; i++) begin
            k    = int'($urandom_range(0, 3));
            base = (k == 0) ? int'($urandom_range(1, 6)) :
                   (k == 1) ? int'($urandom_range(248, 254)) : int'($urandom_range(1, 254));
            e2   = base + int'($urandom_range(0, 60)) - 30;
            if (e2 < 1) e2 = 1;
            if (e2 > 254) e2 = 254;
            a = rand_operand(base);
            b = rand_operand(e2);
            o = 1'($urandom);
            if ($urandom_range(0, 5) == 0) begin
                b = a ^ 32'($urandom_range(0, 15));
                o = (a[31] == b[31]);
            end
            ref_model(a, b, o, er, ef);
            run_op(a, b, o, r, f, lat);
            n_vec += 2;
            if (r !== er) begin n_err++; $display("FAIL rnd%0d_result: a=%h b=%h op=%b got %h want %h", i, a, b, o, r, er); end
            if (f !== ef) begin n_err++; $display("FAIL rnd%0d_flags: a=%h b=%h op=%b got %b want %b", i, a, b, o, f, ef); end
        end
    endtask

    task automatic test_back_to_back_stall();
        logic [31:0] r;
        logic [2:0]  f;
        int lat;
        out_ready = 1'b0;
        run_op(32'h3F800000, 32'h40000000, 1'b0, r, f, lat);
        n_vec += 2;
        if (r !== 32'h40400000) begin n_err++; $display("FAIL stall_result: got %h want 40400000", r); end
        if (lat !== 5)          begin n_err++; $display("FAIL stall_latency: got %0d want 5", lat); end
        for (int c = 0; c < 3; c++) begin
            dataa = 32'h41200000; datab = 32'h41200000; op = 1'b0; in_valid = 1'b1;
            @(negedge clk);
            n_vec += 3;
            if (result !== 32'h40400000) begin n_err++; $display("FAIL stall_hold%0d: got %h want 40400000", c, result); end
            if (out_valid !== 1'b1)      begin n_err++; $display("FAIL stall_valid%0d: got %b want 1", c, out_valid); end
            if (in_ready !== 1'b0)       begin n_err++; $display("FAIL stall_ready%0d: got %b want 0", c, in_ready); end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        n_vec += 2;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL stall_release_valid: got %b want 0", out_valid); end
        if (in_ready !== 1'b1)  begin n_err++; $display("FAIL stall_release_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] r;
        logic [2:0]  f;
        int lat, seen;
        dataa = 32'h3F800000; datab = 32'h40000000; op = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_vec++;
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL midrst_in_ready: got %b want 0", in_ready); end
        reset = 1'b0;
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL midrst_release_ready: got %b want 1", in_ready); end
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        n_vec++;
        if (seen !== 0) begin n_err++; $display("FAIL midrst_no_output: out_valid cycles %0d want 0", seen); end
        run_op(32'h40200000, 32'hBF000000, 1'b0, r, f, lat);
        n_vec += 2;
        if (r !== 32'h40000000) begin n_err++; $display("FAIL midrst_next_result: got %h want 40000000", r); end
        if (f !== 3'b000)       begin n_err++; $display("FAIL midrst_next_flags: got %b want 000", f); end
    endtask

    task automatic test_wide();
        int t, lat;
        t = 0;
        while (!w_in_ready && t < 20) begin @(negedge clk); t++; end
        w_a = 64'h3FF0000000000000; w_b = 64'h4000000000000000; w_op = 1'b0; w_in_valid = 1'b1;
        @(negedge clk);
        w_in_valid = 1'b0;
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            if (w_out_valid) begin lat = c; break; end
            @(negedge clk);
        end
        n_vec += 3;
        if (w_result !== 64'h4008000000000000) begin n_err++; $display("FAIL wide_result: got %h want 4008000000000000", w_result); end
        if (w_flags !== 3'b000) begin n_err++; $display("FAIL wide_flags: got %b want 000", w_flags); end
        if (lat !== 5)          begin n_err++; $display("FAIL wide_latency: got %0d want 5", lat); end
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; op = 1'b0; dataa = '0; datab = '0; out_ready = 1'b1;
        w_in_valid = 1'b0; w_op = 1'b0; w_a = '0; w_b = '0; w_out_ready = 1'b1;
        test_reset();
        test_directed();
        test_back_to_back_stall();
        test_reset_mid_op();
        test_wide();
        test_random(400);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
